// File: rtl/capture_log_pkg.sv
// Shared encodings and helpers for the multi-channel capture logger.
package capture_log_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CAPTURE = 2'b01,
    POST    = 2'b10,
    FULL    = 2'b11
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_CIRC    = 1'b1;

  // Number of bits needed to represent value (clogb2(15) = 4).
  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/log_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
module log_sdp_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register clears on reset so the logger output reads 0 after a reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/capture_log_ram.sv
// Multi-channel sample logger: one-shot fill or circular pre/post-trigger
// capture into block RAM, with logical (oldest-first) host read-back.
module capture_log_ram
  import capture_log_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int N_CHANNELS = 2,
  parameter  int RAM_DEPTH  = 2**15,
  localparam int AW         = clogb2(RAM_DEPTH-1),
  localparam int DW         = N_CHANNELS*DATA_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_run_log,
  input  logic          i_mode,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  input  logic          i_trigger,
  input  logic [AW-1:0] i_post_count,
  input  logic          i_read_log,
  input  logic [AW-1:0] i_addr_log,
  output logic [DW-1:0] o_data_log,
  output logic          o_data_valid,
  output logic          o_mem_full,
  output logic          o_busy,
  output logic [AW-1:0] o_trig_addr,
  output logic [1:0]    o_state
);

  localparam logic [AW-1:0] ONE  = AW'(1);
  localparam logic [AW-1:0] LAST = AW'(RAM_DEPTH-1);

  state_t        state;
  logic          mode;
  logic          wrapped;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] trig_ptr;
  logic [AW-1:0] post_cnt;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] trig_addr;

  // Valid/ready: i_valid is a one-cycle strobe with no back-pressure; every
  // high cycle in CAPTURE/POST is one RAM write. i_read_log is likewise a
  // strobe, honoured only in FULL, answered by o_data_valid one cycle later.
  logic          we;
  logic          rd_en;
  logic          trig_acc;
  logic [AW-1:0] wr_ptr_nxt;
  logic [AW-1:0] trig_now;
  logic [AW-1:0] raddr;

  assign we         = i_valid && (state == CAPTURE || state == POST);
  assign rd_en      = i_read_log && (state == FULL);
  assign trig_acc   = i_trigger && (state == CAPTURE) && (mode == MODE_CIRC) && wrapped;
  assign wr_ptr_nxt = we ? wr_ptr + ONE : wr_ptr;
  // With no write on the trigger cycle, the newest stored sample is the trigger.
  assign trig_now   = i_valid ? wr_ptr : wr_ptr - ONE;
  assign raddr      = start_addr + i_addr_log;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      mode         <= MODE_ONESHOT;
      wrapped      <= 1'b0;
      wr_ptr       <= '0;
      trig_ptr     <= '0;
      post_cnt     <= '0;
      start_addr   <= '0;
      trig_addr    <= '0;
      o_data_valid <= 1'b0;
      o_mem_full   <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      o_data_valid <= rd_en;
      o_busy       <= (state == CAPTURE) || (state == POST);
      o_mem_full   <= (state == FULL);

      if (we) begin
        wr_ptr <= wr_ptr_nxt;
        if (wr_ptr == LAST) wrapped <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (i_run_log) begin
            state   <= CAPTURE;
            wr_ptr  <= '0;
            wrapped <= 1'b0;
            mode    <= i_mode;
          end
        end
        CAPTURE: begin
          if (mode == MODE_ONESHOT) begin
            if (we && wr_ptr == LAST) begin
              state      <= FULL;
              start_addr <= '0;
              trig_addr  <= '0;
            end
          end else if (trig_acc) begin
            trig_ptr <= trig_now;
            post_cnt <= i_post_count;
            if (i_post_count == '0) begin
              state      <= FULL;
              start_addr <= wr_ptr_nxt;
              trig_addr  <= trig_now - wr_ptr_nxt;
            end else begin
              state <= POST;
            end
          end
        end
        POST: begin
          if (we) begin
            post_cnt <= post_cnt - ONE;
            if (post_cnt == ONE) begin
              state      <= FULL;
              start_addr <= wr_ptr_nxt;
              trig_addr  <= trig_ptr - wr_ptr_nxt;
            end
          end
        end
        FULL: begin
          if (i_run_log && !i_read_log) begin
            state   <= CAPTURE;
            wr_ptr  <= '0;
            wrapped <= 1'b0;
            mode    <= i_mode;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_trig_addr = trig_addr;
  assign o_state     = state;

  log_sdp_ram #(
    .WIDTH (DW),
    .DEPTH (RAM_DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (i_data),
    .re    (rd_en),
    .raddr (raddr),
    .rdata (o_data_log)
  );

endmodule
